// File: rtl/accum_pkg.sv
// Shared types and helpers for the multi-channel accumulator.
package accum_pkg;

   typedef enum logic {ACC_WRAP, ACC_SAT} acc_mode_e;

   // Channel tag width; at least one bit even for degenerate channel counts.
   function automatic int unsigned ch_width(input int unsigned num_ch);
      return (num_ch < 2) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/accum_mc_if.sv
// Sample, read-request and readout signals of accum_mc; master drives samples/requests.
interface accum_mc_if #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ACC_WIDTH  = 8,
   parameter int unsigned CH_W       = 2
);
   logic                  clear_all;
   logic                  in_valid;
   logic [CH_W-1:0]       in_ch;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  rd_req;
   logic [CH_W-1:0]       rd_ch;
   logic                  rd_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [CH_W-1:0]       out_ch;
   logic [ACC_WIDTH-1:0]  out_sum;
   logic                  out_ovf;
   logic                  ovf_any;

   modport master (
      output clear_all, in_valid, in_ch, in_data, rd_req, rd_ch, out_ready,
      input  rd_ready, out_valid, out_ch, out_sum, out_ovf, ovf_any
   );

   modport slave (
      input  clear_all, in_valid, in_ch, in_data, rd_req, rd_ch, out_ready,
      output rd_ready, out_valid, out_ch, out_sum, out_ovf, ovf_any
   );
endinterface

// File: rtl/accum_sat_add.sv
// Widening adder with carry-out; optionally clamps to all-ones on carry.
module accum_sat_add
   import accum_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ACC_WIDTH  = 8
) (
   input  logic [ACC_WIDTH-1:0]  a,
   input  logic [DATA_WIDTH-1:0] b,
   input  acc_mode_e             mode,
   output logic [ACC_WIDTH-1:0]  sum,
   output logic                  carry
);
   logic [ACC_WIDTH:0] full;

   always_comb begin
      full  = {1'b0, a} + (ACC_WIDTH+1)'(b);
      carry = full[ACC_WIDTH];
      if (carry && (mode == ACC_SAT)) begin
         sum = '1;
      end else begin
         sum = full[ACC_WIDTH-1:0];
      end
   end
endmodule

// File: rtl/accum_mc.sv
// Multi-channel streaming accumulator with sticky overflow and a read-and-clear readout port.
module accum_mc
   import accum_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ACC_WIDTH  = 8,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned SATURATE   = 0
) (
   input logic       clk,
   input logic       rst,
   accum_mc_if.slave bus
);
   localparam int unsigned CH_W = ch_width(NUM_CH);
   localparam acc_mode_e   Mode = (SATURATE != 0) ? ACC_SAT : ACC_WRAP;

   typedef enum logic {StIdle, StHold} rd_state_e;

   rd_state_e            state_q, state_d;
   logic [ACC_WIDTH-1:0] sum_q [NUM_CH];
   logic [ACC_WIDTH-1:0] sum_d [NUM_CH];
   logic [NUM_CH-1:0]    ovf_q, ovf_d;
   logic                 ovf_any_q;
   logic [CH_W-1:0]      out_ch_q, out_ch_d;
   logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
   logic                 out_ovf_q, out_ovf_d;

   logic                 rd_ready, rd_fire, in_ok, rd_ok;
   logic [ACC_WIDTH-1:0] add_a, add_sum;
   logic                 add_carry;

   assign rd_ready = (state_q == StIdle) || bus.out_ready;
   assign rd_fire  = bus.rd_req && rd_ready;
   assign in_ok    = 32'(bus.in_ch) < NUM_CH;
   assign rd_ok    = 32'(bus.rd_ch) < NUM_CH;

   // A same-channel read clears the sum first, so the sample lands on zero.
   assign add_a = (!in_ok || (rd_fire && (bus.rd_ch == bus.in_ch))) ? '0 : sum_q[bus.in_ch];

   accum_sat_add #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_add (
      .a     (add_a),
      .b     (bus.in_data),
      .mode  (Mode),
      .sum   (add_sum),
      .carry (add_carry)
   );

   always_comb begin
      sum_d = sum_q;
      ovf_d = ovf_q;
      if (bus.clear_all) begin
         sum_d = '{default: '0};
         ovf_d = '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rd_fire && (bus.rd_ch == CH_W'(c))) begin
               sum_d[c] = '0;
               ovf_d[c] = 1'b0;
            end
            if (bus.in_valid && (bus.in_ch == CH_W'(c))) begin
               sum_d[c] = add_sum;
               ovf_d[c] = ovf_d[c] | add_carry;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      out_ch_d  = out_ch_q;
      out_sum_d = out_sum_q;
      out_ovf_d = out_ovf_q;
      if (rd_fire) begin
         state_d   = StHold;
         out_ch_d  = bus.rd_ch;
         out_sum_d = rd_ok ? sum_q[bus.rd_ch] : '0;
         out_ovf_d = rd_ok && ovf_q[bus.rd_ch];
      end else if ((state_q == StHold) && bus.out_ready) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         sum_q     <= '{default: '0};
         ovf_q     <= '0;
         ovf_any_q <= 1'b0;
         out_ch_q  <= '0;
         out_sum_q <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         ovf_q     <= ovf_d;
         ovf_any_q <= |ovf_d;
         out_ch_q  <= out_ch_d;
         out_sum_q <= out_sum_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign bus.rd_ready  = rd_ready;
   assign bus.out_valid = (state_q == StHold);
   assign bus.out_ch    = out_ch_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_ovf   = out_ovf_q;
   assign bus.ovf_any   = ovf_any_q;
endmodule

// File: tb/tb_accum_mc.sv
// Drives a wrap-mode and a saturate-mode accum_mc with identical stimulus against a running-total model.
module tb_accum_mc;
   localparam int unsigned DW  = 4;
   localparam int unsigned AW  = 8;
   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   accum_mc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CH_W(CW)) bw ();
   accum_mc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CH_W(CW)) bs ();

   assign bs.clear_all = bw.clear_all;
   assign bs.in_valid  = bw.in_valid;
   assign bs.in_ch     = bw.in_ch;
   assign bs.in_data   = bw.in_data;
   assign bs.rd_req    = bw.rd_req;
   assign bs.rd_ch     = bw.rd_ch;
   assign bs.out_ready = bw.out_ready;

   accum_mc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_CH(NCH), .SATURATE(0)) u_wrap (
      .clk (clk),
      .rst (rst),
      .bus (bw)
   );

   accum_mc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_CH(NCH), .SATURATE(1)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (bs)
   );

   int tests = 0;
   int fails = 0;

   // Model: unbounded running total per channel since its last clear.
   int total [NCH];
   bit mvalid;
   int cap_ch;
   int cap_tot;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int wrap_of(input int t);
      return t % 256;
   endfunction

   function automatic int sat_of(input int t);
      return (t > 255) ? 255 : t;
   endfunction

   function automatic bit any_ovf();
      bit a = 1'b0;
      for (int i = 0; i < NCH; i++) a |= (total[i] > 255);
      return a;
   endfunction

   task automatic drive(input bit iv, input int ich, input int idat, input bit rq, input int rch,
                        input bit ordy, input bit clr);
      bw.in_valid  = iv;
      bw.in_ch     = CW'(ich);
      bw.in_data   = DW'(idat);
      bw.rd_req    = rq;
      bw.rd_ch     = CW'(rch);
      bw.out_ready = ordy;
      bw.clear_all = clr;
   endtask

   task automatic check_all();
      chk("rd_ready", {31'b0, bw.rd_ready}, {31'b0, (!mvalid || bw.out_ready)});
      chk("out_valid_w", {31'b0, bw.out_valid}, {31'b0, mvalid});
      chk("out_valid_s", {31'b0, bs.out_valid}, {31'b0, mvalid});
      if (mvalid) begin
         chk("out_ch_w", 32'(bw.out_ch), cap_ch);
         chk("out_ch_s", 32'(bs.out_ch), cap_ch);
         chk("out_sum_w", 32'(bw.out_sum), wrap_of(cap_tot));
         chk("out_sum_s", 32'(bs.out_sum), sat_of(cap_tot));
         chk("out_ovf_w", {31'b0, bw.out_ovf}, {31'b0, (cap_tot > 255)});
         chk("out_ovf_s", {31'b0, bs.out_ovf}, {31'b0, (cap_tot > 255)});
      end
      chk("ovf_any_w", {31'b0, bw.ovf_any}, {31'b0, any_ovf()});
      chk("ovf_any_s", {31'b0, bs.ovf_any}, {31'b0, any_ovf()});
   endtask

   // Apply current inputs to the model, advance one edge, then compare.
   task automatic tick();
      bit acc;
      acc = bw.rd_req && (!mvalid || bw.out_ready);
      if (acc) begin
         cap_ch  = int'(bw.rd_ch);
         cap_tot = total[bw.rd_ch];
         total[bw.rd_ch] = 0;
      end
      if (bw.clear_all) begin
         for (int i = 0; i < NCH; i++) total[i] = 0;
      end else if (bw.in_valid) begin
         total[bw.in_ch] += int'(bw.in_data);
      end
      if (acc) mvalid = 1'b1;
      else if (bw.out_ready) mvalid = 1'b0;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) total[i] = 0;
      mvalid  = 1'b0;
      cap_ch  = 0;
      cap_tot = 0;
   endtask

   initial begin
      model_reset();
      drive(0, 0, 0, 0, 0, 1, 0);
      rst = 1'b1;
      #12;
      rst = 1'b0;
      chk("rst_out_valid", {31'b0, bw.out_valid}, 32'd0);
      chk("rst_out_sum", 32'(bw.out_sum), 32'd0);
      chk("rst_out_ch", 32'(bw.out_ch), 32'd0);
      chk("rst_out_ovf", {31'b0, bw.out_ovf}, 32'd0);
      chk("rst_ovf_any", {31'b0, bs.ovf_any}, 32'd0);

      // 10 x 0xF to ch2, then read and re-read ch2
      drive(1, 2, 15, 0, 0, 1, 0);
      repeat (10) tick();
      drive(0, 0, 0, 1, 2, 1, 0);
      tick();
      chk("t1_sum", 32'(bw.out_sum), 32'h96);
      tick();
      chk("t1_reread", 32'(bw.out_sum), 32'h00);
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();

      // 18 x 0xF to ch1: wrap vs saturate
      drive(1, 1, 15, 0, 0, 1, 0);
      repeat (18) tick();
      chk("t2_ovf_any", {31'b0, bw.ovf_any}, 32'd1);
      drive(0, 0, 0, 1, 1, 1, 0);
      tick();
      chk("t2_wrap_sum", 32'(bw.out_sum), 32'h0E);
      chk("t2_sat_sum", 32'(bs.out_sum), 32'hFF);
      chk("t2_ovf", {31'b0, bw.out_ovf}, 32'd1);

      // ch0 = 0x20, read with a same-cycle sample to ch0
      drive(1, 0, 15, 0, 0, 1, 0);
      tick();
      tick();
      drive(1, 0, 2, 0, 0, 1, 0);
      tick();
      drive(1, 0, 5, 1, 0, 1, 0);
      tick();
      chk("t3_pre_add", 32'(bw.out_sum), 32'h20);
      drive(0, 0, 0, 1, 0, 1, 0);
      tick();
      chk("t3_after", 32'(bw.out_sum), 32'h05);

      // Hold readout of ch3 for 5 cycles while ch1 keeps accumulating
      drive(1, 3, 9, 0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 1, 3, 0, 0);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(1, 1, 3, 1, 1, 0, 0);
         tick();
         chk("t4_hold_sum", 32'(bw.out_sum), 32'd9);
         chk("t4_hold_rdy", {31'b0, bw.rd_ready}, 32'd0);
      end
      drive(0, 0, 0, 1, 1, 1, 0);
      tick();
      chk("t4_accum", 32'(bw.out_sum), 32'd15);

      // Back-to-back reads of ch0..ch3
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 1, k, 1, 0);
         tick();
         chk("t5_order", 32'(bw.out_ch), k);
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();

      // clear_all discards a same-cycle sample
      drive(1, 3, 7, 0, 0, 1, 1);
      tick();
      drive(0, 0, 0, 1, 3, 1, 0);
      tick();
      chk("t6_clear", 32'(bw.out_sum), 32'd0);

      // Async reset while holding a readout
      drive(1, 2, 4, 0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 1, 2, 0, 0);
      tick();
      chk("t6_in_hold", {31'b0, bw.out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid_w", {31'b0, bw.out_valid}, 32'd0);
      chk("t6_rst_valid_s", {31'b0, bs.out_valid}, 32'd0);
      drive(0, 0, 0, 0, 0, 1, 0);
      model_reset();
      #1;
      rst = 1'b0;
      tick();

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(1, 0) == 1, $urandom_range(NCH - 1, 0), $urandom_range(15, 0),
               $urandom_range(2, 0) == 0, $urandom_range(NCH - 1, 0),
               $urandom_range(3, 0) != 0, $urandom_range(63, 0) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
